change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter TUBE_W, default 8: width of each coin-tube inventory counter.
REQ-002 Parameter TUBE_INIT, default 5: tube count loaded on reset and on refill.
REQ-003 Parameter PAY_GAP, default 2: idle cycles between consecutive coin ejections.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 coin_in  input  2  accepted-coin code from the vending controller: 0 none, 1/2/3 = denominations worth 1/2/5 units, one cycle per coin.
REQ-007 change_req  input  1  one-cycle request to pay out change_amt.
REQ-008 change_amt  input  16  change value in units, sampled with change_req.
REQ-009 refill  input  1  reload all tubes to TUBE_INIT.
REQ-010 coin_ready  input  1  ejector accepts the presented coin.
REQ-011 coin_code  output  2  denomination code being ejected.
REQ-012 coin_valid  output  1  coin_code is valid.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 short_amt  output  16  unpaid remainder, valid while done is high, held afterwards.
REQ-016 left_c1, left_c2, left_c3  output  TUBE_W each  current tube inventories.

Function
REQ-017 FSM states SHALL be IDLE, SELECT, ISSUE, GAP and FINISH.
REQ-018 IDLE: change_req high latches change_amt into remaining; next state SELECT. change_req outside IDLE SHALL be ignored.
REQ-019 SELECT: picks the largest denomination with value <= remaining and a nonzero tube (priority 5, 2, 1); next ISSUE with coin_code set. If none qualifies, next FINISH.
REQ-020 ISSUE: coin_valid high and coin_code stable until the cycle coin_valid and coin_ready are both high; on that edge the tube decrements by 1, remaining drops by the coin value, and the next state is GAP.
REQ-021 GAP: coin_valid low for exactly PAY_GAP cycles, then SELECT. PAY_GAP = 0 SHALL go directly to SELECT.
REQ-022 FINISH: done high for one cycle, short_amt = remaining, then IDLE.
REQ-023 change_req in cycle t with change_amt = 0 SHALL give done high in cycle t+2, with no coin_valid.
REQ-024 Nonzero coin_in SHALL increment the matching tube on the next edge in any state, saturating at 2^TUBE_W-1.
REQ-025 Deposit and ejection on the same tube in the same cycle SHALL leave that tube unchanged.
REQ-026 refill SHALL act only in IDLE and takes priority over a same-cycle coin_in. change_req in the same cycle is still accepted.
REQ-027 Remaining arithmetic SHALL be 16-bit unsigned and cannot underflow, because of REQ-019.

Reset
REQ-028 RESET SHALL force state IDLE, remaining 0, tubes TUBE_INIT, coin_code 0, coin_valid 0, busy 0, done 0 and short_amt 0 on the next edge.
REQ-029 RESET mid-payout SHALL abort without a done pulse; the coin in flight is not counted.

Structure
REQ-030 A shared package SHALL hold the coin code constants (NONE=0, C1=1, C2=2, C3=3), the denomination values (1, 2, 5) and the FSM state enum.
REQ-031 One sub-module, coin_tube (saturating up/down counter with load), SHALL be instantiated three times.

Verification
REQ-032 Tubes 5/5/5, change_amt=8, coin_ready tied high -> codes 3, 2, 1 with PAY_GAP gaps; tubes 4/4/4; done; short_amt=0.
REQ-033 change_amt=0 -> done exactly 2 cycles after change_req; no coin_valid; short_amt=0.
REQ-034 Tubes 5/5/0, change_amt=10 -> five code-2 coins; left_c2=0; short_amt=0.
REQ-035 Tubes 1/1/1, change_amt=20 -> codes 3, 2, 1, then done with short_amt=12; all tubes 0.
REQ-036 coin_ready held low for 5 cycles during ISSUE -> coin_code stable and tube unchanged; the decrement occurs only on the handshake cycle.
REQ-037 RESET asserted during GAP -> IDLE, tubes back to 5, no done; a deposit of coin_in=3 with tube at 255 -> stays 255.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin codes, coin values and FSM states.
package change_dispenser_pkg;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_C1   = 2'd1;
  localparam logic [1:0] COIN_C2   = 2'd2;
  localparam logic [1:0] COIN_C3   = 2'd3;

  localparam logic [15:0] VAL_C1 = 16'd1;
  localparam logic [15:0] VAL_C2 = 16'd2;
  localparam logic [15:0] VAL_C3 = 16'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Unit value of a coin code; COIN_NONE is worth nothing.
  function automatic logic [15:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_C1: coin_value = VAL_C1;
      COIN_C2: coin_value = VAL_C2;
      COIN_C3: coin_value = VAL_C3;
      default: coin_value = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_coin_tube.sv
// One coin tube inventory: saturating up/down counter with a reload to the
// initial fill. A simultaneous deposit and ejection cancel out.
module coin_tube #(
  parameter int W    = 8,
  parameter int INIT = 5
) (
  input  logic         clk,
  input  logic         RESET,
  input  logic         load,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_C  = {W{1'b1}};
  localparam logic [W-1:0] ZERO_C = {W{1'b0}};
  localparam logic [W-1:0] ONE_C  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] INIT_C = W'(INIT);

  // Inventory update: reset/refill win, then deposit/ejection with saturation.
  always_ff @(posedge clk) begin
    if (RESET) begin
      count <= INIT_C;
    end else if (load) begin
      count <= INIT_C;
    end else if (inc && !dec) begin
      if (count != MAX_C) count <= count + ONE_C;
      else                count <= count;
    end else if (dec && !inc) begin
      if (count != ZERO_C) count <= count - ONE_C;
      else                 count <= count;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a requested amount greedily from three coin tubes
// (5, 2, 1 units), one coin per ready/valid handshake with a fixed idle gap
// between ejections, and reports any unpaid remainder.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int TUBE_W    = 8,
  parameter int TUBE_INIT = 5,
  parameter int PAY_GAP   = 2
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [1:0]        coin_in,
  input  logic              change_req,
  input  logic [15:0]       change_amt,
  input  logic              refill,
  input  logic              coin_ready,
  output logic [1:0]        coin_code,
  output logic              coin_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       short_amt,
  output logic [TUBE_W-1:0] left_c1,
  output logic [TUBE_W-1:0] left_c2,
  output logic [TUBE_W-1:0] left_c3
);

  localparam logic [TUBE_W-1:0] EMPTY_C  = {TUBE_W{1'b0}};
  localparam logic [15:0]       GAP_LOAD = (PAY_GAP > 0) ? 16'(PAY_GAP - 1) : 16'd0;

  state_t      state_r;
  logic [15:0] remaining_r;
  logic [15:0] gap_cnt_r;
  logic [1:0]  pick_s;
  logic        handshake_s;
  logic        load_s;

  // Largest affordable denomination that still has coins in its tube.
  always_comb begin
    pick_s = COIN_NONE;
    if (remaining_r >= VAL_C3 && left_c3 != EMPTY_C) begin
      pick_s = COIN_C3;
    end else if (remaining_r >= VAL_C2 && left_c2 != EMPTY_C) begin
      pick_s = COIN_C2;
    end else if (remaining_r >= VAL_C1 && left_c1 != EMPTY_C) begin
      pick_s = COIN_C1;
    end else begin
      pick_s = COIN_NONE;
    end
  end

  assign handshake_s = (state_r == ST_ISSUE) && coin_valid && coin_ready;
  assign load_s      = refill && (state_r == ST_IDLE);

  coin_tube #(.W(TUBE_W), .INIT(TUBE_INIT)) u_tube_c1 (
    .clk   (clk),
    .RESET (RESET),
    .load  (load_s),
    .inc   (coin_in == COIN_C1),
    .dec   (handshake_s && (coin_code == COIN_C1)),
    .count (left_c1)
  );

  coin_tube #(.W(TUBE_W), .INIT(TUBE_INIT)) u_tube_c2 (
    .clk   (clk),
    .RESET (RESET),
    .load  (load_s),
    .inc   (coin_in == COIN_C2),
    .dec   (handshake_s && (coin_code == COIN_C2)),
    .count (left_c2)
  );

  coin_tube #(.W(TUBE_W), .INIT(TUBE_INIT)) u_tube_c3 (
    .clk   (clk),
    .RESET (RESET),
    .load  (load_s),
    .inc   (coin_in == COIN_C3),
    .dec   (handshake_s && (coin_code == COIN_C3)),
    .count (left_c3)
  );

  // Payout sequencer with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_r     <= ST_IDLE;
      remaining_r <= 16'd0;
      gap_cnt_r   <= 16'd0;
      coin_code   <= COIN_NONE;
      coin_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      short_amt   <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (change_req) begin
            remaining_r <= change_amt;
            busy        <= 1'b1;
            state_r     <= ST_SELECT;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_SELECT: begin
          if (pick_s != COIN_NONE) begin
            coin_code  <= pick_s;
            coin_valid <= 1'b1;
            state_r    <= ST_ISSUE;
          end else begin
            done      <= 1'b1;
            short_amt <= remaining_r;
            state_r   <= ST_FINISH;
          end
        end
        ST_ISSUE: begin
          if (handshake_s) begin
            remaining_r <= remaining_r - coin_value(coin_code);
            coin_valid  <= 1'b0;
            coin_code   <= COIN_NONE;
            gap_cnt_r   <= GAP_LOAD;
            state_r     <= (PAY_GAP == 0) ? ST_SELECT : ST_GAP;
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == 16'd0) begin
            state_r <= ST_SELECT;
          end else begin
            gap_cnt_r <= gap_cnt_r - 16'd1;
            state_r   <= ST_GAP;
          end
        end
        ST_FINISH: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          coin_valid <= 1'b0;
          coin_code  <= COIN_NONE;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
